fpcvt_pipe: RTL and testbench



---
 rtl/fpcvt_pkg.sv | 15 +
 rtl/fpcvt_if.sv | 36 +++
 rtl/fpcvt_lzd.sv | 21 ++
 rtl/fpcvt_pipe.sv | 177 +++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpcvt_pkg.sv
// fpcvt shared types: rounding modes and exponent range helper.
// Optional out_sat port is enabled by defining FPCVT_SAT_FLAG_EN.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2
    } rnd_mode_t;

    function automatic int calc_emax(input int in_w, input int man_w);
        return in_w - 1 - man_w;
    endfunction

endpackage

// File: rtl/fpcvt_if.sv
// fpcvt stream interface: input sample side and output float side.
// out_sat exists only when FPCVT_SAT_FLAG_EN is defined.
interface fpcvt_if #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_s;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_f;
`ifdef FPCVT_SAT_FLAG_EN
    logic             out_sat;
`endif

    modport slave (
        input  in_valid, in_data, rnd_mode, out_ready,
`ifdef FPCVT_SAT_FLAG_EN
        output out_sat,
`endif
        output in_ready, out_valid, out_s, out_e, out_f
    );

    modport master (
        output in_valid, in_data, rnd_mode, out_ready,
`ifdef FPCVT_SAT_FLAG_EN
        input  out_sat,
`endif
        input  in_ready, out_valid, out_s, out_e, out_f
    );
endinterface

// File: rtl/fpcvt_lzd.sv
// fpcvt leading-one detector: index of the highest set bit of a_i.
// zero_o flags an all-zero input (p_o is then 0).
module fpcvt_lzd #(
    parameter int W  = 11,
    parameter int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  a_i,
    output logic [PW-1:0] p_o,
    output logic          zero_o
);
    always_comb begin
        p_o    = '0;
        zero_o = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) begin
                p_o    = PW'(i);
                zero_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage int -> sign/exp/mantissa converter with back-pressure.
// Define FPCVT_SAT_FLAG_EN to add the registered out_sat flag.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input logic   clk,
    input logic   rst,
    fpcvt_if.slave bus
);
    localparam int MW   = IN_W - 1;
    localparam int PW   = (MW > 1) ? $clog2(MW) : 1;
    localparam int EMAX = calc_emax(IN_W, MAN_W);

    if ((2 ** EXP_W) - 1 < EMAX) begin : g_param_chk
        $error("fpcvt_pipe: EXP_W too small for IN_W/MAN_W");
    end

    logic ld1, ld2, ld3;
    logic v1_q, v2_q, v3_q;

    logic             s1_s_q, s1_s_d;
    logic [MW-1:0]    s1_mag_q, s1_mag_d;
    logic             s1_tr_q, s1_tr_d;
    logic             s1_he_q, s1_he_d;
    logic [IN_W-1:0]  neg, abs_v;

    logic             s2_s_q;
    logic [EXP_W-1:0] s2_e_q, s2_e_d;
    logic [MAN_W-1:0] s2_f_q, s2_f_d;
    logic             s2_g_q, s2_g_d;
    logic             s2_st_q, s2_st_d;
    logic             s2_tr_q, s2_he_q;
    logic [PW-1:0]    lz_p;
    logic             lz_zero;
    int               shamt;

    logic             s3_s_q;
    logic [EXP_W-1:0] s3_e_q, s3_e_d;
    logic [MAN_W-1:0] s3_f_q, s3_f_d;
    logic             inc;

`ifdef FPCVT_SAT_FLAG_EN
    logic s1_sat_q, s2_sat_q, s3_sat_q, s3_sat_d;
`endif

    assign ld3 = !v3_q || bus.out_ready;
    assign ld2 = !v2_q || ld3;
    assign ld1 = !v1_q || ld2;
    assign bus.in_ready = ld1 && !rst;

    // Only the most-negative input keeps the top bit set after negation.
    always_comb begin
        s1_s_d   = bus.in_data[IN_W-1];
        neg      = -bus.in_data;
        abs_v    = s1_s_d ? neg : bus.in_data;
        s1_mag_d = abs_v[IN_W-1] ? '1 : abs_v[MW-1:0];
        s1_tr_d  = bus.rnd_mode == RND_TRUNC;
        s1_he_d  = bus.rnd_mode == RND_HALF_EVEN;
    end

    fpcvt_lzd #(.W(MW), .PW(PW)) u_lzd (
        .a_i    (s1_mag_q),
        .p_o    (lz_p),
        .zero_o (lz_zero)
    );

    always_comb begin
        shamt   = int'(lz_p) - MAN_W;
        s2_e_d  = '0;
        s2_f_d  = s1_mag_q[MAN_W-1:0];
        s2_g_d  = 1'b0;
        s2_st_d = 1'b0;
        if (!lz_zero && shamt >= 0) begin
            s2_e_d  = EXP_W'(shamt + 1);
            s2_f_d  = MAN_W'(s1_mag_q >> (shamt + 1));
            s2_g_d  = |(s1_mag_q & (MW'(1) << shamt));
            s2_st_d = |(s1_mag_q & ~({MW{1'b1}} << shamt));
        end
    end

    always_comb begin
        inc = s2_tr_q ? 1'b0
            : s2_he_q ? (s2_g_q && (s2_st_q || s2_f_q[0]))
            : s2_g_q;
        s3_e_d = s2_e_q;
        s3_f_d = s2_f_q;
`ifdef FPCVT_SAT_FLAG_EN
        s3_sat_d = s2_sat_q;
`endif
        if (inc) begin
            if (!(&s2_f_q)) begin
                s3_f_d = s2_f_q + 1'b1;
            end else if (s2_e_q < EXP_W'(EMAX)) begin
                s3_f_d = {1'b1, {(MAN_W-1){1'b0}}};
                s3_e_d = s2_e_q + 1'b1;
            end
`ifdef FPCVT_SAT_FLAG_EN
            else begin
                s3_sat_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s1_s_q   <= 1'b0;
            s1_mag_q <= '0;
            s1_tr_q  <= 1'b0;
            s1_he_q  <= 1'b0;
            s2_s_q   <= 1'b0;
            s2_e_q   <= '0;
            s2_f_q   <= '0;
            s2_g_q   <= 1'b0;
            s2_st_q  <= 1'b0;
            s2_tr_q  <= 1'b0;
            s2_he_q  <= 1'b0;
            s3_s_q   <= 1'b0;
            s3_e_q   <= '0;
            s3_f_q   <= '0;
`ifdef FPCVT_SAT_FLAG_EN
            s1_sat_q <= 1'b0;
            s2_sat_q <= 1'b0;
            s3_sat_q <= 1'b0;
`endif
        end else begin
            if (ld1) begin
                v1_q     <= bus.in_valid;
                s1_s_q   <= s1_s_d;
                s1_mag_q <= s1_mag_d;
                s1_tr_q  <= s1_tr_d;
                s1_he_q  <= s1_he_d;
`ifdef FPCVT_SAT_FLAG_EN
                s1_sat_q <= abs_v[IN_W-1];
`endif
            end
            if (ld2) begin
                v2_q    <= v1_q;
                s2_s_q  <= s1_s_q;
                s2_e_q  <= s2_e_d;
                s2_f_q  <= s2_f_d;
                s2_g_q  <= s2_g_d;
                s2_st_q <= s2_st_d;
                s2_tr_q <= s1_tr_q;
                s2_he_q <= s1_he_q;
`ifdef FPCVT_SAT_FLAG_EN
                s2_sat_q <= s1_sat_q;
`endif
            end
            if (ld3) begin
                v3_q   <= v2_q;
                s3_s_q <= s2_s_q;
                s3_e_q <= s3_e_d;
                s3_f_q <= s3_f_d;
`ifdef FPCVT_SAT_FLAG_EN
                s3_sat_q <= s3_sat_d;
`endif
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.out_s     = s3_s_q;
    assign bus.out_e     = s3_e_q;
    assign bus.out_f     = s3_f_q;
`ifdef FPCVT_SAT_FLAG_EN
    assign bus.out_sat   = s3_sat_q;
`endif

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: directed vectors, back-pressure, reset, random.
// Checks against an arithmetic reference model; honours FPCVT_SAT_FLAG_EN.
module tb_fpcvt_pipe;

    typedef struct {
        bit s;
        int e;
        int f;
        bit sat;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpcvt_if bus_if ();

    fpcvt_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   n_emit = 0;
    int   n_disc = 0;
    bit   lat_on = 1'b0;
    bit   or_rand = 1'b0;
    logic or_val = 1'b0;
    bit   hold_pend = 1'b0;
    int   hold_bits = 0;
    exp_t q[$];

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Pure arithmetic reference: scale mag into [8,15], round the remainder.
    function automatic exp_t model(input logic [11:0] d, input logic [1:0] m);
        exp_t r;
        int v, mag, e, f, rem, half;
        bit inc;
        v = int'($signed(d));
        r.sat = 1'b0;
        r.s = (v < 0);
        mag = r.s ? -v : v;
        if (mag > 2047) begin
            mag = 2047;
            r.sat = 1'b1;
        end
        e = 0;
        while ((mag >> e) > 15) e++;
        f = mag >> e;
        rem = mag - (f << e);
        inc = 1'b0;
        if (e > 0) begin
            half = 1 << (e - 1);
            case (m)
                2'd0: inc = 1'b0;
                2'd2: inc = (rem > half) || (rem == half && f % 2 == 1);
                default: inc = (rem >= half);
            endcase
        end
        if (inc) begin
            f++;
            if (f == 16) begin
                if (e < 7) begin
                    f = 8;
                    e++;
                end else begin
                    f = 15;
                    r.sat = 1'b1;
                end
            end
        end
        r.e = e;
        r.f = f;
        r.cyc = 0;
        return r;
    endfunction

    always begin
        @(posedge clk);
        #2;
        bus_if.out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_val;
    end

    always @(negedge clk) begin
        exp_t r;
        cyc++;
        if (rst) begin
            n_disc += q.size();
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                chk("hold", int'({bus_if.out_valid, bus_if.out_s,
                                  bus_if.out_e, bus_if.out_f}), hold_bits);
            if (bus_if.out_valid && bus_if.out_ready) begin
                n_emit++;
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    r = q.pop_front();
                    chk("out_s", int'(bus_if.out_s), int'(r.s));
                    chk("out_e", int'(bus_if.out_e), r.e);
                    chk("out_f", int'(bus_if.out_f), r.f);
`ifdef FPCVT_SAT_FLAG_EN
                    chk("out_sat", int'(bus_if.out_sat), int'(r.sat));
`endif
                    if (lat_on) chk("latency", cyc - r.cyc, 3);
                end
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                r = model(bus_if.in_data, bus_if.rnd_mode);
                r.cyc = cyc;
                q.push_back(r);
                n_acc++;
            end
            hold_pend = bus_if.out_valid && !bus_if.out_ready;
            hold_bits = int'({bus_if.out_valid, bus_if.out_s,
                              bus_if.out_e, bus_if.out_f});
        end
    end

    task automatic send(input logic [11:0] d, input logic [1:0] m);
        int n;
        bus_if.in_data  = d;
        bus_if.rnd_mode = m;
        bus_if.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.in_ready && n < 200);
        if (!bus_if.in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic vec(input string nm, input logic [11:0] d, input logic [1:0] m,
                       input int es, input int ee, input int ef, input int esat);
        exp_t r;
        r = model(d, m);
        chk({nm, "_s"}, int'(r.s), es);
        chk({nm, "_e"}, r.e, ee);
        chk({nm, "_f"}, r.f, ef);
        chk({nm, "_sat"}, int'(r.sat), esat);
        send(d, m);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] corner [8];
        int n;
        corner = '{12'h800, 12'h7FF, 12'h001, 12'hFFF,
                   12'h00F, 12'h010, 12'hFF0, 12'h01F};
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.rnd_mode = 2'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus_if.out_valid), 0);
        chk("rst_out_s", int'(bus_if.out_s), 0);
        chk("rst_out_e", int'(bus_if.out_e), 0);
        chk("rst_out_f", int'(bus_if.out_f), 0);
        chk("rst_in_ready", int'(bus_if.in_ready), 0);
`ifdef FPCVT_SAT_FLAG_EN
        chk("rst_out_sat", int'(bus_if.out_sat), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_val = 1'b1;
        idle(2);

        lat_on = 1'b1;
        vec("d125", 12'h07D, 2'd1, 0, 4, 8, 0);
        vec("d0", 12'h000, 2'd1, 0, 0, 0, 0);
        vec("m100_hu", 12'hF9C, 2'd1, 1, 3, 13, 0);
        vec("m100_he", 12'hF9C, 2'd2, 1, 3, 12, 0);
        vec("m100_tr", 12'hF9C, 2'd0, 1, 3, 12, 0);
        vec("m100_r3", 12'hF9C, 2'd3, 1, 3, 13, 0);
        vec("sat_neg", 12'h800, 2'd1, 1, 7, 15, 1);
        vec("max_tr", 12'h7FF, 2'd0, 0, 7, 15, 0);
        vec("max_hu", 12'h7FF, 2'd1, 0, 7, 15, 1);
        vec("he_odd", 12'h01B, 2'd2, 0, 1, 14, 0);
        idle(6);
        lat_on = 1'b0;

        or_val = 1'b0;
        vec("bp0", 12'h010, 2'd1, 0, 1, 8, 0);
        vec("bp1", 12'h020, 2'd1, 0, 2, 8, 0);
        vec("bp2", 12'h030, 2'd1, 0, 2, 12, 0);
        bus_if.in_data  = 12'h040;
        bus_if.rnd_mode = 2'd1;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", int'(bus_if.in_ready), 0);
        end
        @(posedge clk);
        #1;
        or_val = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_rel", int'(bus_if.in_ready), 1);
        chk("bp_gap0", int'(bus_if.out_valid), 1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp_gap", int'(bus_if.out_valid), 1);
        end
        idle(4);

        or_val = 1'b0;
        send(12'h123, 2'd1);
        send(12'h456, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", int'(bus_if.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_out_valid", int'(bus_if.out_valid), 0);
        end
        @(posedge clk);
        #1;
        vec("post_rst", 12'h07D, 2'd1, 0, 4, 8, 0);
        idle(5);

        for (int i = 0; i < 8; i++)
            for (int m = 0; m < 4; m++)
                send(corner[i], 2'(m));

        or_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send(12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        or_rand = 1'b0;
        or_val  = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
        chk("acc_vs_emit", n_emit, n_acc - n_disc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
